game_input_arbiter: RTL
=======================

# game_input_arbiter

Sequences and shares the single-digit game counter between two players. Takes the level button requests of player 0 and player 1 (already debounced) and turns them into single-cycle `inc_btn`/`dec_btn` pulses for the counter, never both in one cycle. Simultaneous requests are resolved round-robin. An optional auto-repeat generates further pulses while a button is held. Sits between the debounce stage and the counter.

## Interface
- `REPEAT_DELAY`, default 25_000_000: cycles from accepted press to first repeat pulse (≥2).
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent repeat pulses (≥2).
- `TMR_W`, default 25: timer width; must hold max(REPEAT_DELAY, REPEAT_PERIOD).
- `clk` in 1: system clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: 0 freezes the game (no pulses, pending requests dropped).
- `p0_inc`, `p0_dec` in 1 each: player 0 button levels.
- `p1_inc`, `p1_dec` in 1 each: player 1 button levels.
- `inc_btn` out 1: registered one-cycle increment pulse to the counter.
- `dec_btn` out 1: registered one-cycle decrement pulse to the counter.
- `grant` out 2: one-hot owner of the current pulse (bit0 = p0, bit1 = p1); 0 when no pulse.
- `busy` out 1: registered; 1 while any request is pending.

## Operation
- Effective request per player: INC if inc&!dec, DEC if dec&!inc, NONE otherwise (both pressed = NONE).
- Previous effective request is registered per player. A press event occurs when the effective request changes to INC or DEC, including a direct INC↔DEC change.
- Press event sets that player's pending flag and stores its direction. A new event while pending overwrites the direction and keeps a single pending entry.
- Pending entries are served even if the button is released before service.
- Arbiter issues at most one pulse per cycle:
  - One pending player: that player is granted.
  - Both pending: the player indicated by the round-robin pointer is granted, and the pointer moves to the other player.
  - Single grants also point the pointer at the other player.
- A grant clears that player's pending flag. The pulse goes out on `inc_btn` or `dec_btn` per the stored direction, with the matching `grant` bit set.
- `enable`=0:
  - Pending flags cleared; outputs held 0.
  - Repeat FSMs forced to IDLE.
  - Previous-request registers still update, so a button held across re-enable produces no pulse until released and pressed again.
- Reset values: `inc_btn`=0, `dec_btn`=0, `grant`=0, `busy`=0. Pointer = player 0. Pending cleared. Previous requests = NONE, so a button held through reset release produces exactly one press event.

## Timing
- Uncontested press: effective request first sampled active at edge k; pulse high for exactly cycle k+1 (edge k+1 to k+2).
- Contested same-cycle presses: winner pulses at k+1, loser at k+2.
- `busy` is 1 from edge k until the edge at which the last pending flag clears.
- Worst-case service latency of a pending entry: 2 cycles.
- No back-pressure: the counter accepts every pulse.
- Auto-repeat FSM per player (states IDLE, DELAY, REPEAT):
  - IDLE → DELAY on a press event; timer loaded with REPEAT_DELAY−1.
  - DELAY/REPEAT: timer decrements each cycle while the effective request equals the stored direction. At timer 0 the pending flag is set and the FSM moves to REPEAT with timer REPEAT_PERIOD−1.
  - Release (NONE) → IDLE.
  - Direction change → DELAY, reloaded as a new press event.
  - First repeat pulse comes REPEAT_DELAY cycles after the original press pulse (uncontested); later pulses every REPEAT_PERIOD cycles.
  - A repeat expiring while still pending merges into the existing pending entry; no queueing.

## Configuration
- `GAME_AUTO_REPEAT_EN` defined: repeat FSMs and timers present; parameters honoured.
- `GAME_AUTO_REPEAT_EN` undefined: FSMs and timers removed. Exactly one pulse per press event. REPEAT_DELAY, REPEAT_PERIOD and TMR_W are ignored. All other behaviour is identical.

## Test plan
- Reset with `reset_n`=0 mid-pulse → all outputs 0 immediately. Release with p0_inc held → one `inc_btn`, `grant`=01, at cycle 1 after the first sampling edge; no more pulses with repeat off.
- p0_inc and p1_dec rise in the same cycle after reset → `inc_btn`/`grant`=01 at k+1, then `dec_btn`/`grant`=10 at k+2. Repeat in the next cycle → p1 served first.
- p0_inc and p0_dec both high → no pulse. Release p0_dec → one `inc_btn`.
- `enable`=0 while p1_inc is pressed → no pulse and `busy`=0. Re-enable with the button still held → no pulse. Release and press again → one pulse.
- With `GAME_AUTO_REPEAT_EN`, REPEAT_DELAY=8, REPEAT_PERIOD=4, p0_dec held 20 cycles → pulses at cycles 1, 9, 13, 17. Release → pulses stop, FSM returns to IDLE.
- With `GAME_AUTO_REPEAT_EN`, both players hold with equal timers → pulses alternate p0/p1 on consecutive cycles and never overlap.

Source files
------------

// File: rtl/game_input_arbiter.sv
// game_input_arbiter: shares the game counter between two players by turning their button levels into inc/dec pulses.
// Latency: a pulse comes one cycle after the press is sampled. The loser of a simultaneous press pulses one cycle later (2 cycles worst case).
// Backpressure: none. Every pulse is accepted. A repeat that fires while a press is still waiting merges into that single pending entry.
//
// Optional feature: define GAME_AUTO_REPEAT_EN to build the held-button auto-repeat
// FSMs (REPEAT_DELAY, REPEAT_PERIOD, TMR_W). Without it those parameters are ignored.
//
// Ports:
//   clk                 rising-edge system clock
//   reset_n             asynchronous active-low reset
//   enable              0 freezes the game: no pulses, pending requests dropped
//   p0_inc, p0_dec      player 0 debounced button levels
//   p1_inc, p1_dec      player 1 debounced button levels
//   inc_btn, dec_btn    registered one-cycle pulses to the counter (never both)
//   grant[1:0]          one-hot owner of the current pulse (bit0 = p0), 0 when idle
//   busy                registered, high while any request is pending
module game_input_arbiter #(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int TMR_W         = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       p0_inc,
    input  logic       p0_dec,
    input  logic       p1_inc,
    input  logic       p1_dec,
    output logic       inc_btn,
    output logic       dec_btn,
    output logic [1:0] grant,
    output logic       busy
);

    // Per-player vectors: bit0 = player 0, bit1 = player 1.
    logic [1:0] btn_inc;
    logic [1:0] btn_dec;
    logic [1:0] eff_inc;
    logic [1:0] eff_dec;
    logic [1:0] prev_inc;
    logic [1:0] prev_dec;
    logic [1:0] press;
    logic [1:0] pend;
    logic [1:0] pend_nxt;
    logic [1:0] dir_dec;     // stored direction: 1 = decrement
    logic [1:0] gnt;
    logic [1:0] rpt_set;
    logic       rr_ptr;      // 0: player 0 wins the next tie

    assign btn_inc = {p1_inc, p0_inc};
    assign btn_dec = {p1_dec, p0_dec};

    // Both buttons pressed counts as no request.
    assign eff_inc = btn_inc & ~btn_dec;
    assign eff_dec = btn_dec & ~btn_inc;

    // A press is any change into INC or DEC. This includes a direct INC<->DEC swap.
    assign press = (eff_inc & ~prev_inc) | (eff_dec & ~prev_dec);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (&pend) begin
                gnt = rr_ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = pend;
            end
        end
    end

    // A fresh press or repeat in the same cycle as a grant re-arms the entry.
    assign pend_nxt = enable ? ((pend & ~gnt) | press | rpt_set) : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_inc <= 2'b00;
            prev_dec <= 2'b00;
            pend     <= 2'b00;
            dir_dec  <= 2'b00;
            rr_ptr   <= 1'b0;
            busy     <= 1'b0;
            inc_btn  <= 1'b0;
            dec_btn  <= 1'b0;
            grant    <= 2'b00;
        end else begin
            // History keeps tracking while disabled. As a result, a button held across
            // re-enable does not count as a new press.
            prev_inc <= eff_inc;
            prev_dec <= eff_dec;
            pend     <= pend_nxt;
            busy     <= |pend_nxt;
            if (enable) begin
                dir_dec <= (dir_dec & ~press) | (eff_dec & press);
            end
            // After any grant, the other player gets priority on the next tie.
            if (|gnt) begin
                rr_ptr <= gnt[0];
            end
            inc_btn <= |(gnt & ~dir_dec);
            dec_btn <= |(gnt & dir_dec);
            grant   <= gnt;
        end
    end

`ifdef GAME_AUTO_REPEAT_EN
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [TMR_W-1:0] DLY_LOAD = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_LOAD = TMR_W'(REPEAT_PERIOD - 1);

    logic [1:0] same_dir;
    logic [1:0] held;

    assign same_dir = (eff_inc & ~dir_dec) | (eff_dec & dir_dec);
    assign held     = eff_inc | eff_dec;

    genvar gp;
    generate
        for (gp = 0; gp < 2; gp++) begin : g_rpt
            logic [1:0]       state;
            logic [TMR_W-1:0] tmr;

            // A press that lands on the same cycle as a timer expiry restarts the delay.
            assign rpt_set[gp] = enable && (state != ST_IDLE) && !press[gp]
                                 && same_dir[gp] && (tmr == '0);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state <= ST_IDLE;
                    tmr   <= '0;
                end else if (!enable) begin
                    state <= ST_IDLE;
                    tmr   <= '0;
                end else if (press[gp]) begin
                    state <= ST_DELAY;
                    tmr   <= DLY_LOAD;
                end else if (state != ST_IDLE) begin
                    if (!held[gp]) begin
                        state <= ST_IDLE;
                    end else if (same_dir[gp]) begin
                        if (tmr == '0) begin
                            state <= ST_REPEAT;
                            tmr   <= PER_LOAD;
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end
                end
            end
        end
    endgenerate
`else
    assign rpt_set = 2'b00;

    // The repeat parameters have no meaning in this build.
    logic unused_cfg;
    assign unused_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD), 32'(TMR_W)};
`endif

endmodule
